rx_token_lexer: RTL

Sits directly downstream of the JTAG UART receive FIFO in the RPN calculator. Pulls bytes from the FIFO read port, converts ASCII decimal digit runs into binary numbers, and classifies operator, end-of-line and illegal characters. Emits one token at a time to the calculator core over a valid/ready handshake. Applies backpressure to the FIFO by not reading while a token is pending.

---
 rtl/rx_token_lexer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rx_token_lexer.sv
// rx_token_lexer
// Pulls bytes from the UART receive FIFO and turns them into calculator
// tokens. Runs of decimal digits become NUM tokens. Operators, line ends
// and illegal bytes become OP, EOL and ERR tokens. Only one token moves at
// a time, over a valid/ready handshake.
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for FIFO data; no token pending
// RD      | read strobe to the FIFO (one cycle)
// CAP     | FIFO data valid; capture into byte register
// DEC     | classify byte; accumulate digit or present token(s)
// EMIT    | token presented; wait for handshake
// EMIT2   | NUM presented with a second token stashed behind it
//
// Ports:
//   clk_i        system clock (FIFO read-side clock)
//   nreset_i     synchronous active-low reset
//   rx_empty_i   FIFO empty flag
//   rx_rd_o      one-cycle FIFO read strobe
//   rx_data_i    FIFO data, valid the edge after the strobe cycle
//   tok_valid_o  token available
//   tok_ready_i  consumer accepts token
//   tok_kind_o   00 NUM, 01 OP, 10 EOL, 11 ERR
//   tok_value_o  NUM value, or ASCII byte for OP/ERR, or 0 for EOL
//   tok_ovf_o    NUM wrapped modulo 2^W during accumulation
module rx_token_lexer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         nreset_i,
    input  logic         rx_empty_i,
    output logic         rx_rd_o,
    input  logic [7:0]   rx_data_i,
    output logic         tok_valid_o,
    input  logic         tok_ready_i,
    output logic [1:0]   tok_kind_o,
    output logic [W-1:0] tok_value_o,
    output logic         tok_ovf_o
);

    localparam int AW = W + 4;

    localparam logic [1:0] K_NUM = 2'b00;
    localparam logic [1:0] K_OP  = 2'b01;
    localparam logic [1:0] K_EOL = 2'b10;
    localparam logic [1:0] K_ERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        CAP   = 3'd2,
        DEC   = 3'd3,
        EMIT  = 3'd4,
        EMIT2 = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     byte_q;
    logic [W-1:0]   acc_q;
    logic           in_num_q;
    logic           ovf_q;
    logic [1:0]     stash_kind_q;
    logic [W-1:0]   stash_value_q;

    logic           is_digit;
    logic           is_space;
    logic [1:0]     cls_kind;
    logic [W-1:0]   cls_value;
    logic [AW-1:0]  acc_wide;

    // Byte classification and digit accumulation. The accumulator is widened
    // by four bits so acc*10+d never loses the carry used for the wrap flag.
    always_comb begin
        is_digit  = (byte_q >= 8'h30) && (byte_q <= 8'h39);
        is_space  = (byte_q == 8'h20);
        cls_kind  = K_ERR;
        cls_value = W'(byte_q);
        acc_wide  = AW'(acc_q) * AW'(10) + AW'(byte_q[3:0]);
        case (byte_q)
            8'h2B, 8'h2D, 8'h2A, 8'h2F: cls_kind = K_OP;
            8'h0D, 8'h0A: begin
                cls_kind  = K_EOL;
                cls_value = '0;
            end
            default: cls_kind = K_ERR;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rx_rd_o = 1'b0;
        case (state_q)
            IDLE:  if (!tok_valid_o && !rx_empty_i) state_d = RD;
            RD: begin
                rx_rd_o = 1'b1;
                state_d = CAP;
            end
            CAP:   state_d = DEC;
            DEC: begin
                if (is_digit)      state_d = IDLE;
                else if (is_space) state_d = in_num_q ? EMIT : IDLE;
                else               state_d = in_num_q ? EMIT2 : EMIT;
            end
            EMIT:  if (tok_ready_i) state_d = IDLE;
            EMIT2: if (tok_ready_i) state_d = EMIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q       <= IDLE;
            byte_q        <= '0;
            acc_q         <= '0;
            in_num_q      <= 1'b0;
            ovf_q         <= 1'b0;
            stash_kind_q  <= K_NUM;
            stash_value_q <= '0;
            tok_valid_o   <= 1'b0;
            tok_kind_o    <= K_NUM;
            tok_value_o   <= '0;
            tok_ovf_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                CAP: byte_q <= rx_data_i;
                DEC: begin
                    if (is_digit) begin
                        acc_q    <= acc_wide[W-1:0];
                        in_num_q <= 1'b1;
                        if (|acc_wide[AW-1:W]) ovf_q <= 1'b1;
                    end else if (in_num_q) begin
                        // Number ends here; it goes out first and the
                        // delimiter (if not a space) waits in the stash.
                        tok_valid_o   <= 1'b1;
                        tok_kind_o    <= K_NUM;
                        tok_value_o   <= acc_q;
                        tok_ovf_o     <= ovf_q;
                        acc_q         <= '0;
                        in_num_q      <= 1'b0;
                        ovf_q         <= 1'b0;
                        stash_kind_q  <= cls_kind;
                        stash_value_q <= cls_value;
                    end else if (!is_space) begin
                        tok_valid_o <= 1'b1;
                        tok_kind_o  <= cls_kind;
                        tok_value_o <= cls_value;
                        tok_ovf_o   <= 1'b0;
                    end
                end
                EMIT: if (tok_ready_i) tok_valid_o <= 1'b0;
                EMIT2: begin
                    if (tok_ready_i) begin
                        tok_kind_o  <= stash_kind_q;
                        tok_value_o <= stash_value_q;
                        tok_ovf_o   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
